// File: rtl/jpeg_uart_pkg.sv
// jpeg_uart_pkg
//   Shared types and constants for the jpeg/UART command sequencer.
//   rx_state_t    : RX frame parser states
//   reply_state_t : 2-byte status reply sequencer states
//   CMD_*         : command byte codes
//   REPLY_HDR     : first byte of every status reply
//   STAT_*        : bit positions inside the status byte
//   pack_status   : assembles the status byte from its fields
package jpeg_uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        CFG_ARG = 3'd2,
        LEN_HI  = 3'd3,
        LEN_LO  = 3'd4,
        STREAM  = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        RP_NONE = 2'd0,
        RP_HDR  = 2'd1,
        RP_STAT = 2'd2
    } reply_state_t;

    localparam logic [7:0] CMD_CFG    = 8'h01;
    localparam logic [7:0] CMD_STREAM = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;
    localparam logic [7:0] REPLY_HDR  = 8'h5A;

    localparam int STAT_ONE     = 0;
    localparam int STAT_JFULL   = 1;
    localparam int STAT_TXOVF   = 2;
    localparam int STAT_BAD_CMD = 3;
    localparam int STAT_TMO     = 4;
    localparam int STAT_BUSY    = 5;
    localparam int STAT_MUX_LO  = 6;

    function automatic logic [7:0] pack_status(
        input logic [1:0] mux,
        input logic       busy,
        input logic       tmo,
        input logic       bad_cmd,
        input logic       txovf,
        input logic       jfull
    );
        logic [7:0] s;
        s                            = 8'h00;
        s[STAT_MUX_LO+1:STAT_MUX_LO] = mux;
        s[STAT_BUSY]                 = busy;
        s[STAT_TMO]                  = tmo;
        s[STAT_BAD_CMD]              = bad_cmd;
        s[STAT_TXOVF]                = txovf;
        s[STAT_JFULL]                = jfull;
        s[STAT_ONE]                  = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/jpeg_uart_txmux.sv
// jpeg_uart_txmux
//   UART TX byte arbiter. The jpeg output stream has strict priority; a
//   pending status reply (header byte, then live status byte) only uses
//   cycles with no jpeg byte and room in the TX FIFO. Output is registered.
// Ports
//   clk, rst          clock, async active-high reset
//   jpeg_dout[_valid] jpeg output byte stream (cannot be stalled)
//   tx_full           UART TX FIFO full
//   reply_req         1-cycle request for a status reply (ignored if one is pending)
//   status_byte       live status byte, captured when the second reply byte goes out
//   tx_valid, tx_data registered TX byte strobe and data
//   txovf_set         pulse: jpeg byte presented while TX FIFO was full
//   status_sent       pulse: status byte captured this cycle (sticky flags clear)
//
//   state   | meaning
//   RP_NONE | no reply pending
//   RP_HDR  | reply pending, header byte 5A next
//   RP_STAT | header sent, status byte next
module jpeg_uart_txmux
    import jpeg_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] jpeg_dout,
    input  logic       jpeg_dout_valid,
    input  logic       tx_full,
    input  logic       reply_req,
    input  logic [7:0] status_byte,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       txovf_set,
    output logic       status_sent
);

    reply_state_t rp_q, rp_d;
    logic         load;
    logic [7:0]   load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp_q     <= RP_NONE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            rp_q     <= rp_d;
            tx_valid <= load;
            if (load) begin
                tx_data <= load_data;
            end
        end
    end

    always_comb begin
        rp_d        = rp_q;
        load        = 1'b0;
        load_data   = jpeg_dout;
        txovf_set   = 1'b0;
        status_sent = 1'b0;

        if (jpeg_dout_valid) begin
            // jpeg cannot be stalled: present the byte even into a full FIFO
            load      = 1'b1;
            load_data = jpeg_dout;
            txovf_set = tx_full;
        end else if (rp_q != RP_NONE && !tx_full) begin
            load = 1'b1;
            if (rp_q == RP_HDR) begin
                load_data = REPLY_HDR;
                rp_d      = RP_STAT;
            end else begin
                load_data   = status_byte;
                status_sent = 1'b1;
                rp_d        = RP_NONE;
            end
        end

        if (reply_req && rp_q == RP_NONE) begin
            rp_d = RP_HDR;
        end
    end

endmodule

// File: rtl/jpeg_uart_ctrl.sv
// jpeg_uart_ctrl
//   Command sequencer between the UART and the jpeg core. Parses framed
//   RX commands (SYNC, CMD, args), drives the jpeg output-mux select, gates
//   length-bounded pixel streams into jpeg din, and keeps sticky error flags.
// Ports
//   clk, rst                    clock, async active-high reset
//   rx_valid, rx_data           UART RX byte strobe / byte
//   tx_full                     UART TX FIFO full
//   tx_valid, tx_data           UART TX byte strobe / byte
//   jpeg_din, jpeg_din_valid    pixel byte to jpeg, 1 cycle after RX
//   jpeg_dout, jpeg_dout_valid  jpeg output stream
//   jpeg_full                   jpeg input buffer full
//   jpeg_mux_out                jpeg output-mux select
//   busy                        frame in progress
//   status                      live flags byte
//
//   state   | meaning
//   IDLE    | hunting for SYNC
//   CMD     | next byte is the command code
//   CFG_ARG | next byte is the mux select argument
//   LEN_HI  | next byte is stream length high byte
//   LEN_LO  | next byte is stream length low byte
//   STREAM  | forwarding payload bytes to jpeg
module jpeg_uart_ctrl
    import jpeg_uart_pkg::*;
#(
    parameter int         LEN_W  = 16,
    parameter int         TO_CYC = 1_000_000,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_full,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [7:0] jpeg_din,
    output logic       jpeg_din_valid,
    input  logic [7:0] jpeg_dout,
    input  logic       jpeg_dout_valid,
    input  logic       jpeg_full,
    output logic [1:0] jpeg_mux_out,
    output logic       busy,
    output logic [7:0] status
);

    localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    rx_state_t        state_q, state_d;
    logic [7:0]       len_hi_q;
    logic [15:0]      len_rx;
    logic [LEN_W-1:0] rem_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             tmo_q, bad_cmd_q, txovf_q, jfull_q;

    logic fwd, cfg_ld, len_ld, reply_req, bad_cmd_set, tmo_set, to_hit;
    logic txovf_set, status_sent;

    assign len_rx = {len_hi_q, rx_data};
    assign busy   = (state_q != IDLE);
    assign status = pack_status(jpeg_mux_out, busy, tmo_q, bad_cmd_q, txovf_q, jfull_q);

    // Down-counter holds idle cycles left before abort; reloads on every RX byte.
    assign to_hit = (state_q != IDLE) && !rx_valid && (to_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        fwd         = 1'b0;
        cfg_ld      = 1'b0;
        len_ld      = 1'b0;
        reply_req   = 1'b0;
        bad_cmd_set = 1'b0;
        tmo_set     = 1'b0;

        if (to_hit) begin
            state_d = IDLE;
            tmo_set = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC) state_d = CMD;
                end
                CMD: begin
                    case (rx_data)
                        CMD_CFG:    state_d = CFG_ARG;
                        CMD_STREAM: state_d = LEN_HI;
                        CMD_STATUS: begin
                            state_d   = IDLE;
                            reply_req = 1'b1;
                        end
                        default: begin
                            state_d     = IDLE;
                            bad_cmd_set = 1'b1;
                        end
                    endcase
                end
                CFG_ARG: begin
                    cfg_ld  = 1'b1;
                    state_d = IDLE;
                end
                LEN_HI: state_d = LEN_LO;
                LEN_LO: begin
                    len_ld  = 1'b1;
                    state_d = (len_rx == 16'h0000) ? IDLE : STREAM;
                end
                STREAM: begin
                    fwd = 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            len_hi_q       <= 8'h00;
            rem_q          <= '0;
            to_cnt_q       <= '0;
            jpeg_mux_out   <= 2'b00;
            jpeg_din       <= 8'h00;
            jpeg_din_valid <= 1'b0;
            tmo_q          <= 1'b0;
            bad_cmd_q      <= 1'b0;
            txovf_q        <= 1'b0;
            jfull_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            jpeg_din_valid <= fwd;
            if (fwd) begin
                jpeg_din <= rx_data;
                rem_q    <= rem_q - LEN_W'(1);
            end
            if (len_ld) begin
                rem_q <= LEN_W'(len_rx);
            end
            if (rx_valid && state_q == LEN_HI) begin
                len_hi_q <= rx_data;
            end
            if (cfg_ld) begin
                jpeg_mux_out <= rx_data[1:0];
            end

            if (rx_valid) begin
                to_cnt_q <= TO_W'(TO_CYC - 1);
            end else if (state_q != IDLE && to_cnt_q != '0) begin
                to_cnt_q <= to_cnt_q - TO_W'(1);
            end

            // A set in the same cycle as the status read-out wins over the clear.
            tmo_q     <= tmo_set              | (tmo_q     & ~status_sent);
            bad_cmd_q <= bad_cmd_set          | (bad_cmd_q & ~status_sent);
            txovf_q   <= txovf_set            | (txovf_q   & ~status_sent);
            jfull_q   <= (fwd && jpeg_full)   | (jfull_q   & ~status_sent);
        end
    end

    jpeg_uart_txmux u_txmux (
        .clk             (clk),
        .rst             (rst),
        .jpeg_dout       (jpeg_dout),
        .jpeg_dout_valid (jpeg_dout_valid),
        .tx_full         (tx_full),
        .reply_req       (reply_req),
        .status_byte     (status),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .txovf_set       (txovf_set),
        .status_sent     (status_sent)
    );

endmodule

// File: tb/tb_jpeg_uart_ctrl.sv
// Testbench for jpeg_uart_ctrl: expected jpeg_din bytes (with their due
// cycle) and expected TX bytes are queued when stimulus is driven and
// compared when the DUT strobes them out.
module tb_jpeg_uart_ctrl;

    localparam int TO_CYC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_full = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [7:0] jpeg_din;
    logic       jpeg_din_valid;
    logic [7:0] jpeg_dout = 8'h00;
    logic       jpeg_dout_valid = 1'b0;
    logic       jpeg_full = 1'b0;
    logic [1:0] jpeg_mux_out;
    logic       busy;
    logic [7:0] status;

    always #5 clk = ~clk;

    jpeg_uart_ctrl #(.LEN_W(16), .TO_CYC(TO_CYC), .SYNC(8'hA5)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .tx_full         (tx_full),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .jpeg_din        (jpeg_din),
        .jpeg_din_valid  (jpeg_din_valid),
        .jpeg_dout       (jpeg_dout),
        .jpeg_dout_valid (jpeg_dout_valid),
        .jpeg_full       (jpeg_full),
        .jpeg_mux_out    (jpeg_mux_out),
        .busy            (busy),
        .status          (status)
    );

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       jq[$];
    logic [7:0] tq[$];
    exp_t       mon_j;
    logic [7:0] mon_t;
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (jpeg_din_valid) begin
            if (jq.size() == 0) begin
                chk("jdin_unexpected", 32'(jpeg_din), 32'hFFFF_FFFF);
            end else begin
                mon_j = jq.pop_front();
                chk("jdin_data", 32'(jpeg_din), 32'(mon_j.d));
                chk("jdin_latency", 32'(cyc), 32'(mon_j.c));
            end
        end
        if (tx_valid) begin
            if (tq.size() == 0) begin
                chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                mon_t = tq.pop_front();
                chk("tx_data", 32'(tx_data), 32'(mon_t));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic stream_byte(input logic [7:0] b);
        exp_t e;
        e.d = b;
        e.c = cyc + 1;
        jq.push_back(e);
        rx_byte(b);
    endtask

    task automatic status_req(input logic [7:0] exp_stat);
        tq.push_back(8'h5A);
        tq.push_back(exp_stat);
        rx_byte(8'hA5);
        rx_byte(8'h03);
        idle(4);
        chk("reply_drained", 32'(tq.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"},  32'(tx_valid),       32'd0);
        chk({tag, "_tx_data"},   32'(tx_data),        32'd0);
        chk({tag, "_jdin"},      32'(jpeg_din),       32'd0);
        chk({tag, "_jdin_vld"},  32'(jpeg_din_valid), 32'd0);
        chk({tag, "_mux"},       32'(jpeg_mux_out),   32'd0);
        chk({tag, "_busy"},      32'(busy),           32'd0);
        chk({tag, "_status"},    32'(status),         32'h01);
    endtask

    initial begin
        // reset
        idle(2);
        chk_reset_outputs("rst");
        rst = 1'b0;
        idle(1);

        // CFG: mux select 2
        rx_byte(8'hA5);
        chk("busy_in_cmd", 32'(busy), 32'd1);
        rx_byte(8'h01);
        rx_byte(8'h02);
        chk("cfg_mux", 32'(jpeg_mux_out), 32'd2);
        chk("cfg_busy", 32'(busy), 32'd0);

        // STREAM of 3, SYNC value inside payload is data
        rx_byte(8'hA5);
        rx_byte(8'h02);
        rx_byte(8'h00);
        rx_byte(8'h03);
        stream_byte(8'h11);
        chk("stream_busy", 32'(busy), 32'd1);
        stream_byte(8'hA5);
        stream_byte(8'h33);
        chk("stream_done_busy", 32'(busy), 32'd0);
        idle(2);
        chk("stream_drained", 32'(jq.size()), 32'd0);

        // zero-length stream
        rx_byte(8'hA5);
        rx_byte(8'h02);
        rx_byte(8'h00);
        rx_byte(8'h00);
        chk("len0_busy", 32'(busy), 32'd0);
        idle(2);

        // STATUS with idle jpeg
        status_req(8'h81);

        // STATUS with jpeg bytes taking both reply slots
        tq.push_back(8'hC1);
        tq.push_back(8'hC2);
        tq.push_back(8'h5A);
        tq.push_back(8'h81);
        rx_byte(8'hA5);
        rx_byte(8'h03);
        jpeg_dout_valid = 1'b1;
        jpeg_dout       = 8'hC1;
        @(negedge clk);
        jpeg_dout       = 8'hC2;
        @(negedge clk);
        jpeg_dout_valid = 1'b0;
        idle(4);
        chk("prio_drained", 32'(tq.size()), 32'd0);

        // bad command, sticky until a status read-out
        rx_byte(8'hA5);
        rx_byte(8'h07);
        chk("bad_cmd_status", 32'(status), 32'h89);
        status_req(8'h89);
        status_req(8'h81);

        // timeout mid-stream
        rx_byte(8'hA5);
        rx_byte(8'h02);
        rx_byte(8'h00);
        rx_byte(8'h05);
        stream_byte(8'h01);
        stream_byte(8'h02);
        idle(TO_CYC - 1);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        idle(1);
        chk("tmo_busy_after", 32'(busy), 32'd0);
        chk("tmo_status", 32'(status), 32'h91);
        status_req(8'h91);

        // byte forwarded while jpeg full
        rx_byte(8'hA5);
        rx_byte(8'h02);
        rx_byte(8'h00);
        rx_byte(8'h01);
        jpeg_full = 1'b1;
        stream_byte(8'h77);
        jpeg_full = 1'b0;
        chk("jfull_status", 32'(status), 32'h83);
        status_req(8'h83);

        // jpeg byte into full TX FIFO
        tq.push_back(8'hD0);
        tx_full         = 1'b1;
        jpeg_dout_valid = 1'b1;
        jpeg_dout       = 8'hD0;
        @(negedge clk);
        jpeg_dout_valid = 1'b0;
        tx_full         = 1'b0;
        chk("txovf_status", 32'(status), 32'h85);
        idle(1);
        status_req(8'h85);

        // reset with reply pending and stream in progress
        tx_full = 1'b1;
        rx_byte(8'hA5);
        rx_byte(8'h03);
        rx_byte(8'hA5);
        rx_byte(8'h02);
        rx_byte(8'h00);
        rx_byte(8'h10);
        stream_byte(8'h44);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        idle(1);
        chk_reset_outputs("midrst");
        rst     = 1'b0;
        tx_full = 1'b0;
        idle(6);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_jq", 32'(jq.size()), 32'd0);
        chk("post_rst_tq", 32'(tq.size()), 32'd0);
        status_req(8'h01);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
